// File: rtl/cam_i2c_responder.sv
// -----------------------------------------------------------------------------
// cam_i2c_responder
//
// I2C/SCCB target that stands in for a camera sensor's control port. It decodes
// sensor-style transactions with a 16-bit register pointer and turns them into
// single-cycle accesses on a simple register bus.
//
// The block oversamples SCL/SDA with the system clock and never stretches SCL.
// Every protocol action is taken on an edge seen in the synchronised domain.
//
// Ports
//   clk        system clock, at least 16x the SCL rate
//   reset      asynchronous, active-low reset
//   scl_i      SCL pad input
//   sda_i      SDA pad input (the resolved open-drain line)
//   sda_oe     1 = pull SDA low, 0 = release
//   reg_addr   current 16-bit register pointer
//   reg_wdata  write data, valid while reg_we = 1
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read request; reg_rdata is sampled on the next clk
//   reg_rdata  read data returned by the register file
//   busy       1 from an addressed START until STOP
//
// Transaction shapes
//   write : S | DEV/W A | ADDR_HI A | ADDR_LO A | DATA A | DATA A ... | P
//   read  : S | DEV/W A | ADDR_HI A | ADDR_LO A | Sr | DEV/R A | DATA a ... DATA n | P
//   A read may also start directly (S | DEV/R ...) and uses the current pointer.
// -----------------------------------------------------------------------------
module cam_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h36,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Protocol states. Each *_ACK state spans from the SCL fall that opens the
  // acknowledge slot to the SCL fall that closes it.
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    RHI,
    RHI_ACK,
    RLO,
    RLO_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_MACK,
    IGNORE
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus one history flop for edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl;
  logic                   sda;

  // NOTE: the synchronisers reset to 1 (the idle bus level) so that leaving
  // reset can never look like a START, STOP or SCL edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its neighbour, which is what turns this into a real shift chain.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  // Bus events in the synchronised domain. START/STOP need SCL high on both
  // samples so they can never coincide with an SCL edge.
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  =  scl & ~scl_prev;
  assign scl_fall  = ~scl &  scl_prev;
  assign start_det =  scl &  scl_prev &  sda_prev & ~sda;
  assign stop_det  =  scl &  scl_prev & ~sda_prev &  sda;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [7:0] shreg;     // receive shift register, MSB first
  logic [7:0] tx_sh;     // transmit shift register, bit 7 is on the wire
  logic [2:0] bit_cnt;   // data bits seen in the current byte
  logic       full;      // 8 bits seen; cleared at the SCL fall that opens ACK
  logic       rw;        // R/W bit of the last device-address byte

  logic [7:0] rx_byte;   // byte including the bit sampled on this SCL rise
  logic       last_rise; // SCL rise that carries the 8th data bit
  logic       byte_end;  // SCL fall that closes a complete byte
  logic       addr_match;
  logic       bit_state; // states in which data bits are clocked

  assign rx_byte    = {shreg[6:0], sda};
  assign last_rise  = scl_rise & (bit_cnt == 3'd7);
  assign byte_end   = scl_fall & full;
  assign addr_match = (shreg[7:1] == DEV_ADDR);
  assign bit_state  = (state == DEV) || (state == RHI) || (state == RLO) ||
                      (state == WDATA) || (state == RDATA);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register and registered outputs
  // ---------------------------------------------------------------------------
  logic sda_oe_nxt;
  logic reg_we_nxt;
  logic reg_re_nxt;
  logic busy_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sda_oe <= sda_oe_nxt;
      reg_we <= reg_we_nxt;
      reg_re <= reg_re_nxt;
      busy   <= busy_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic. STOP beats START beats data handling.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default first assignment keeps this block free of latches on
    // every path that does not change state.
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = DEV;
    end else begin
      case (state)
        DEV:       if (byte_end) state_nxt = addr_match ? DEV_ACK : IGNORE;
        DEV_ACK:   if (scl_fall) state_nxt = rw ? RDATA : RHI;
        RHI:       if (byte_end) state_nxt = RHI_ACK;
        RHI_ACK:   if (scl_fall) state_nxt = RLO;
        RLO:       if (byte_end) state_nxt = RLO_ACK;
        RLO_ACK:   if (scl_fall) state_nxt = WDATA;
        WDATA:     if (byte_end) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_nxt = WDATA;
        RDATA:     if (byte_end) state_nxt = RD_MACK;
        RD_MACK: begin
          // A master NACK ends the read burst; an ACK continues at the fall.
          if (scl_rise && sda)  state_nxt = IGNORE;
          else if (scl_fall)    state_nxt = RDATA;
        end
        default:   state_nxt = state;   // IDLE, IGNORE wait for START/STOP
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: next values of the registered outputs. sda_oe only moves on
  // an SCL fall, so the line is stable for the whole SCL-high phase.
  // ---------------------------------------------------------------------------
  always_comb begin
    sda_oe_nxt = sda_oe;
    reg_we_nxt = 1'b0;
    reg_re_nxt = 1'b0;
    busy_nxt   = busy;
    if (stop_det) begin
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (!start_det) begin
      case (state)
        DEV: begin
          if (byte_end) begin
            sda_oe_nxt = addr_match;   // ACK only our own address
            busy_nxt   = addr_match;
          end
        end
        DEV_ACK: begin
          // The read request goes out at the ACK rise so the first data byte
          // is in tx_sh well before the fall that puts its MSB on the wire.
          if (scl_rise && rw) reg_re_nxt = 1'b1;
          if (scl_fall)       sda_oe_nxt = rw & ~tx_sh[7];
        end
        RHI, RLO: begin
          if (byte_end) sda_oe_nxt = 1'b1;
        end
        WDATA: begin
          if (last_rise) reg_we_nxt = 1'b1;
          if (byte_end)  sda_oe_nxt = 1'b1;
        end
        RHI_ACK, RLO_ACK, WDATA_ACK: begin
          if (scl_fall) sda_oe_nxt = 1'b0;
        end
        RDATA: begin
          // After the 8th bit, release the line for the master's ACK slot;
          // otherwise present the next bit (open drain: only 0 is driven).
          if (scl_fall) sda_oe_nxt = full ? 1'b0 : ~tx_sh[6];
        end
        RD_MACK: begin
          if (scl_rise) begin
            if (sda) busy_nxt   = 1'b0;
            else     reg_re_nxt = 1'b1;
          end
          if (scl_fall) sda_oe_nxt = ~tx_sh[7];
        end
        IGNORE: begin
          sda_oe_nxt = 1'b0;
          busy_nxt   = 1'b0;
        end
        default: begin
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: bit counting, shift registers and the register pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= 8'h00;
      tx_sh     <= 8'h00;
      bit_cnt   <= 3'd0;
      full      <= 1'b0;
      rw        <= 1'b0;
      reg_addr  <= 16'h0000;
      reg_wdata <= 8'h00;
    end else begin
      // Transmit register: load the requested byte the clk after reg_re,
      // otherwise advance one bit at every fall inside a read byte.
      if (reg_re) begin
        tx_sh <= reg_rdata;
      end else if (state == RDATA && scl_fall && !full) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end

      if (start_det || stop_det) begin
        // Abort any byte in flight; the pointer is kept across START.
        bit_cnt <= 3'd0;
        full    <= 1'b0;
      end else begin
        if (bit_state && scl_rise) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;     // wraps to 0 after the 8th bit
          if (bit_cnt == 3'd7) begin
            full <= 1'b1;
            case (state)
              DEV:     rw              <= sda;
              RHI:     reg_addr[15:8]  <= rx_byte;
              RLO:     reg_addr[7:0]   <= rx_byte;
              WDATA:   reg_wdata       <= rx_byte;
              default: ;
            endcase
          end
        end

        if (byte_end) full <= 1'b0;

        // Auto-increment, wrapping naturally at 16 bits: after a written byte
        // has been acknowledged, and when the master ACKs a read byte.
        if (state == WDATA_ACK && scl_fall) begin
          reg_addr <= reg_addr + 16'd1;
        end
        if (state == RD_MACK && scl_rise && !sda) begin
          reg_addr <= reg_addr + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_i2c_responder.sv
// -----------------------------------------------------------------------------
// tb_cam_i2c_responder
//
// Bench for cam_i2c_responder: a behavioural I2C master at 400 kHz against a
// 25 MHz system clock, an open-drain SDA line, a small register-file model and
// a monitor that records register-bus activity.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cam_i2c_responder;

  localparam time CLK_HALF = 20ns;    // 25 MHz
  localparam time Q        = 625ns;   // quarter of a 2.5 us SCL period

  logic        clk;
  logic        reset;
  logic        scl_m;
  logic        sda_m;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Open-drain bus: either side may pull low.
  assign sda_line = sda_m & ~sda_oe;

  cam_i2c_responder #(
    .DEV_ADDR    (7'h36),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  // Register-file model for reads
  function automatic logic [7:0] rf_model(input logic [15:0] a);
    case (a)
      16'h300A: return 8'h56;
      16'h300B: return 8'h47;
      default:  return 8'hEE;
    endcase
  endfunction

  assign reg_rdata = rf_model(reg_addr);

  // Register-bus monitor, sampled on the inactive clock edge
  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  int          re_cnt  = 0;
  int          oe_cnt  = 0;
  int          clash   = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (reg_we) begin
        we_addr_q.push_back(reg_addr);
        we_data_q.push_back(reg_wdata);
      end
      if (reg_re)           re_cnt++;
      if (sda_oe)           oe_cnt++;
      if (reg_we && reg_re) clash++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish within 3 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // I2C master primitives
  // ---------------------------------------------------------------------------
  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    ack   = ~sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q;
      scl_m = 1'b1; #Q;
      b[i]  = sda_line; #Q;
      scl_m = 1'b0; #Q;
    end
    sda_m = ack ? 1'b0 : 1'b1; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Write-transaction vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [6:0]  dev;
    logic [15:0] ptr;
    int          n;
    logic [7:0]  data [3];
    logic        exp_ack;     // target answers this address
    logic [15:0] exp_final;   // reg_addr after STOP
  } wr_vec_t;

  task automatic run_write(input wr_vec_t v);
    int          we_base;
    int          re_base;
    int          oe_base;
    int          n_exp;
    logic        ack;
    logic [15:0] ea;

    we_base = we_addr_q.size();
    re_base = re_cnt;
    oe_base = oe_cnt;
    n_exp   = v.exp_ack ? v.n : 0;

    i2c_start();
    write_byte({v.dev, 1'b0}, ack);
    check({v.name, "_dev_ack"}, ack, v.exp_ack);
    check({v.name, "_busy_on"}, busy, v.exp_ack);
    write_byte(v.ptr[15:8], ack);
    check({v.name, "_ptr_hi_ack"}, ack, v.exp_ack);
    write_byte(v.ptr[7:0], ack);
    check({v.name, "_ptr_lo_ack"}, ack, v.exp_ack);
    for (int i = 0; i < v.n; i++) begin
      write_byte(v.data[i], ack);
      check($sformatf("%s_data%0d_ack", v.name, i), ack, v.exp_ack);
    end
    check({v.name, "_busy_pre_stop"}, busy, v.exp_ack);
    i2c_stop();
    #Q;
    check({v.name, "_busy_post_stop"}, busy, 1'b0);
    check({v.name, "_sda_oe_post_stop"}, sda_oe, 1'b0);
    check({v.name, "_we_count"}, we_addr_q.size() - we_base, n_exp);
    if (we_addr_q.size() - we_base == n_exp) begin
      for (int i = 0; i < n_exp; i++) begin
        ea = v.ptr + 16'(i);
        check($sformatf("%s_we%0d_addr", v.name, i), we_addr_q[we_base + i], ea);
        check($sformatf("%s_we%0d_data", v.name, i), we_data_q[we_base + i], v.data[i]);
      end
    end
    check({v.name, "_re_count"}, re_cnt - re_base, 0);
    check({v.name, "_sda_driven"}, (oe_cnt != oe_base), v.exp_ack);
    check({v.name, "_final_addr"}, reg_addr, v.exp_final);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  wr_vec_t vecs [4];
  wr_vec_t post_reset_vec;

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         re_base;
    int         we_base;

    vecs[0] = '{name: "single_wr", dev: 7'h36, ptr: 16'h0100, n: 1,
                data: '{8'hA5, 8'h00, 8'h00}, exp_ack: 1'b1, exp_final: 16'h0101};
    vecs[1] = '{name: "burst_wr",  dev: 7'h36, ptr: 16'h3000, n: 3,
                data: '{8'h11, 8'h22, 8'h33}, exp_ack: 1'b1, exp_final: 16'h3003};
    vecs[2] = '{name: "other_dev", dev: 7'h3C, ptr: 16'h1234, n: 1,
                data: '{8'h55, 8'h00, 8'h00}, exp_ack: 1'b0, exp_final: 16'h3003};
    vecs[3] = '{name: "wrap_wr",   dev: 7'h36, ptr: 16'hFFFF, n: 2,
                data: '{8'hAA, 8'hBB, 8'h00}, exp_ack: 1'b1, exp_final: 16'h0001};
    post_reset_vec = '{name: "post_reset_wr", dev: 7'h36, ptr: 16'h0055, n: 1,
                       data: '{8'h77, 8'h00, 8'h00}, exp_ack: 1'b1, exp_final: 16'h0056};

    scl_m = 1'b1;
    sda_m = 1'b1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_oe",    sda_oe,    1'b0);
    check("rst_reg_we",    reg_we,    1'b0);
    check("rst_reg_re",    reg_re,    1'b0);
    check("rst_reg_addr",  reg_addr,  16'h0000);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_busy",      busy,      1'b0);
    reset = 1'b1;
    repeat (10) @(posedge clk);

    for (int v = 0; v < 4; v++) run_write(vecs[v]);

    // Pointer 0x300A, repeated START, read with master ACK then NACK
    re_base = re_cnt;
    we_base = we_addr_q.size();
    i2c_start();
    write_byte(8'h6C, ack);  check("rd_dev_w_ack", ack, 1'b1);
    write_byte(8'h30, ack);  check("rd_ptr_hi_ack", ack, 1'b1);
    write_byte(8'h0A, ack);  check("rd_ptr_lo_ack", ack, 1'b1);
    i2c_start();
    write_byte(8'h6D, ack);  check("rd_dev_r_ack", ack, 1'b1);
    check("rd_busy", busy, 1'b1);
    read_byte(rd, 1'b1);     check("rd_byte0", rd, 8'h56);
    read_byte(rd, 1'b0);     check("rd_byte1", rd, 8'h47);
    #Q;
    check("rd_release_after_nack", sda_oe, 1'b0);
    check("rd_busy_after_nack", busy, 1'b0);
    i2c_stop();
    #Q;
    check("rd_re_count", re_cnt - re_base, 2);
    check("rd_we_count", we_addr_q.size() - we_base, 0);
    check("rd_final_addr", reg_addr, 16'h300B);

    // Reset in the middle of a read byte while the target pulls SDA low.
    // Pointer is 0x300B -> 0x47 = 0100_0111; after two bits bit 5 (0) is out.
    i2c_start();
    write_byte(8'h6D, ack);  check("rst_rd_dev_ack", ack, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0;
    end
    #Q;
    check("rst_rd_driving", sda_oe, 1'b1);
    #7;
    reset = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 1'b0);
    check("async_rst_busy",   busy,   1'b0);
    check("async_rst_addr",   reg_addr, 16'h0000);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (10) @(posedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);

    run_write(post_reset_vec);

    check("we_re_overlap", clash, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_i2c_responder.md
Name: cam_i2c_responder

Overview:
I2C/SCCB target that emulates the camera sensor's control port. It answers the camera-init I2C master over SCL/SDA, in simulation and in loop-back builds. The block decodes 16-bit register-address transactions (sensor style) and drives a simple register bus towards an external register file. SCL is oversampled by the system clock; SCL is never stretched.

Parameters:
DEV_ADDR, 7'h36, 7-bit target address answered; all other addresses are ignored.
SYNC_STAGES, 2, synchroniser depth on scl_i/sda_i (minimum 2).

Ports:
clk  in  1  system clock, at least 16x the SCL rate (e.g. 25 MHz pixclk against 400 kHz SCL)
reset  in  1  asynchronous, active-low reset
scl_i  in  1  SCL pad input
sda_i  in  1  SDA pad input
sda_oe  out  1  1 = pull SDA low (open drain); 0 = release
reg_addr  out  16  current register pointer
reg_wdata  out  8  write data, valid while reg_we=1
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read request; reg_rdata is sampled on the next clk
reg_rdata  in  8  read data from the register file
busy  out  1  1 from an addressed START until STOP

Behaviour:
- Reset (reset=0, asynchronous): sda_oe=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, busy=0, state=IDLE.
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detection. Every action below is referenced to the synchronised edge.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- START/STOP detection has priority over data handling in every state.
- Data bits are sampled on the SCL rising edge, MSB first.
- sda_oe changes only on the SCL falling edge, except on STOP and reset.
- Bit counter 0..7 for data bits; the 9th clock is the ACK slot.
- States: IDLE, DEV, DEV_ACK, RHI, RHI_ACK, RLO, RLO_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
- START (including repeated START) from any state -> DEV. Counter is cleared; reg_addr is retained.
- STOP from any state -> IDLE, with sda_oe=0 and busy=0 on the same clk.
- DEV, 8 bits received:
  - Address matches DEV_ADDR -> DEV_ACK. sda_oe=1 from the next SCL fall through the following SCL fall.
  - Mismatch -> IGNORE. No ACK; the block stays silent until START/STOP.
- DEV_ACK, R/W=0 -> RHI. The byte sets reg_addr[15:8]. RHI_ACK -> RLO, which sets reg_addr[7:0]. RLO_ACK -> WDATA.
- DEV_ACK, R/W=1 -> RDATA:
  - reg_re pulses on the clk of the SCL rise of the ACK bit.
  - reg_rdata is latched into the shift register on the next clk.
  - The first bit is driven at the SCL fall ending the ACK.
  - Driving 0 sets sda_oe=1; driving 1 sets sda_oe=0.
- WDATA, byte complete (8th SCL rise):
  - reg_wdata is loaded and reg_we=1 for exactly one clk, with the current reg_addr.
  - The block ACKs (WDATA_ACK), then reg_addr increments at the SCL fall ending the ACK.
  - Next state is WDATA.
- RDATA, after 8 bits: sda_oe=0 for the master ACK slot (RD_MACK), sampled at SCL rise.
  - ACK (SDA=0): reg_addr increments, reg_re pulses on the following clk, data is latched, and the next byte is driven (RDATA).
  - NACK: -> IGNORE (release the bus, wait for STOP/START).
- reg_addr wraps 16'hFFFF -> 16'h0000 on increment.
- A read without a preceding pointer write uses the current reg_addr.
- A START/STOP in the middle of a byte aborts that byte: no reg_we, no increment.
- reg_we and reg_re never assert in the same clk.
- busy=1 from the DEV_ACK state onward; it clears in IDLE and IGNORE.

Test Plan:
- Write 36/W, 0x01,0x00, 0xA5 then STOP at 400 kHz, clk 25 MHz -> ACK on all 4 bytes; one reg_we with reg_addr=0x0100, reg_wdata=0xA5; busy falls at STOP.
- Burst write at pointer 0x3000: 0x11,0x22,0x33 -> reg_we x3 at 0x3000/0x3001/0x3002; final reg_addr=0x3003.
- Pointer 0x300A, repeated START, 36/R, master ACK then NACK, register file returns 0x56,0x47 -> SDA carries 0x56 then 0x47; reg_re x2; block releases SDA after NACK.
- Address 0x3C/W with DEV_ADDR=0x36 -> SDA never pulled low; no reg_we/reg_re; busy stays 0.
- Pointer 0xFFFF, write 0xAA,0xBB -> writes to 0xFFFF then 0x0000.
- Assert reset mid-byte during a read while sda_oe=1 -> sda_oe=0 immediately (async). After release, a fresh write transaction succeeds with reg_addr restarted from the written pointer.
